// File: rtl/mod_n_counter_if.sv
// Bus for mod_n_counter: step controls in, count/tc/wrap out.
// load/din exist only when MOD_LOAD_EN is defined.
interface mod_n_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
`ifdef MOD_LOAD_EN
    logic             load;
    logic [WIDTH-1:0] din;

    modport master (
        output en, up, load, din,
        input  count, tc, wrap
    );
    modport slave (
        input  en, up, load, din,
        output count, tc, wrap
    );
`else
    modport master (
        output en, up,
        input  count, tc, wrap
    );
    modport slave (
        input  en, up,
        output count, tc, wrap
    );
`endif
endinterface

// File: rtl/mod_n_counter.sv
// Up/down modulo-N counter with prescaler, cascadable tc and wrap pulse.
// Define MOD_LOAD_EN to add a synchronous load of din.
module mod_n_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 10,
    parameter int PRESCALE = 1
) (
    input  logic           clk,
    input  logic           clr,
    mod_n_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] ld_val;
    logic             ld;
    logic             step;
    logic             at_max;
    logic             at_zero;
    logic             tc;
    logic             wrap_q;

`ifdef MOD_LOAD_EN
    // Out-of-range load data saturates to the top of the sequence.
    assign ld     = bus.load;
    assign ld_val = ({1'b0, bus.din} >= (WIDTH+1)'(MODULUS))
                  ? CNT_MAX : bus.din;
`else
    assign ld     = 1'b0;
    assign ld_val = '0;
`endif

    generate
        if (PRESCALE > 1) begin : g_pre
            localparam int PW = $clog2(PRESCALE);
            localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
            logic [PW-1:0] pre_q;

            always_ff @(posedge clk) begin
                if (clr || ld)
                    pre_q <= '0;
                else if (bus.en)
                    pre_q <= (pre_q == PRE_MAX) ? '0 : pre_q + PW'(1);
            end

            assign step = bus.en && (pre_q == PRE_MAX);
        end else begin : g_nopre
            assign step = bus.en;
        end
    endgenerate

    always_comb begin
        at_max  = (count_q == CNT_MAX);
        at_zero = (count_q == '0);
        tc      = step && !ld && (bus.up ? at_max : at_zero);
        count_d = count_q;
        if (ld)
            count_d = ld_val;
        else if (step && bus.up)
            count_d = at_max ? '0 : count_q + WIDTH'(1);
        else if (step)
            count_d = at_zero ? CNT_MAX : count_q - WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= tc;
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc;
    assign bus.wrap  = wrap_q;
endmodule

// File: tb/tb_mod_n_counter.sv
// Self-checking bench for mod_n_counter: directed scenarios plus
// randomized stimulus against an arithmetic reference model.
module tb_mod_n_counter;
    logic clk;
    logic clr;
    logic clrc;
    int   n_chk;
    int   n_fail;

    mod_n_counter_if #(.WIDTH(4)) ifa ();
    mod_n_counter_if #(.WIDTH(4)) ifb ();
    mod_n_counter_if #(.WIDTH(4)) ifd ();
    mod_n_counter_if #(.WIDTH(4)) ifu ();
    mod_n_counter_if #(.WIDTH(4)) ift ();

    mod_n_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1))
        dut_a (.clk(clk), .clr(clr), .bus(ifa));
    mod_n_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3))
        dut_b (.clk(clk), .clr(clr), .bus(ifb));
    mod_n_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(2))
        dut_d (.clk(clk), .clr(clr), .bus(ifd));
    mod_n_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1))
        dut_u (.clk(clk), .clr(clrc), .bus(ifu));
    mod_n_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1))
        dut_t (.clk(clk), .clr(clrc), .bus(ift));

    assign ift.en = ifu.tc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int pre;
        int wrap;
    } mst_t;

    mst_t  ms[3];
    int    md[3] = '{10, 10, 16};
    int    ps[3] = '{1, 3, 2};
    string nm[3] = '{"a", "b", "d"};

    function automatic bit m_tc(mst_t s, int m, int p,
                                bit e, bit u, bit l);
        bit stp = e && (s.pre == p - 1);
        return stp && !l && (u ? s.cnt == m - 1 : s.cnt == 0);
    endfunction

    function automatic mst_t m_next(mst_t s, int m, int p, bit c,
                                    bit e, bit u, bit l, int d);
        mst_t n = s;
        n.wrap = c ? 0 : int'(m_tc(s, m, p, e, u, l));
        if (c) begin
            n.cnt = 0;
            n.pre = 0;
        end else if (l) begin
            n.cnt = (d >= m) ? m - 1 : d;
            n.pre = 0;
        end else if (e) begin
            if (s.pre == p - 1)
                n.cnt = (s.cnt + (u ? 1 : m - 1)) % m;
            n.pre = (s.pre + 1) % p;
        end
        return n;
    endfunction

    // One clock of shared stimulus on a, b and d; entered and left at negedge.
    task automatic cyc(input bit c, input bit e, input bit u,
                       input bit l, input int d);
        logic       gt[3];
        logic [3:0] gc[3];
        logic       gw[3];
        bit         et;
        clr = c;
        ifa.en = e; ifb.en = e; ifd.en = e;
        ifa.up = u; ifb.up = u; ifd.up = u;
`ifdef MOD_LOAD_EN
        ifa.load = l; ifb.load = l; ifd.load = l;
        ifa.din = 4'(d); ifb.din = 4'(d); ifd.din = 4'(d);
`endif
        #1;
        gt = '{ifa.tc, ifb.tc, ifd.tc};
        for (int k = 0; k < 3; k++) begin
            et = m_tc(ms[k], md[k], ps[k], e, u, l);
            n_chk++;
            if (gt[k] !== et) begin
                n_fail++;
                $display("FAIL tc_%s got %b exp %b t=%0t",
                         nm[k], gt[k], et, $time);
            end
            ms[k] = m_next(ms[k], md[k], ps[k], c, e, u, l, d);
        end
        @(posedge clk);
        @(negedge clk);
        gc = '{ifa.count, ifb.count, ifd.count};
        gw = '{ifa.wrap, ifb.wrap, ifd.wrap};
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (gc[k] !== 4'(ms[k].cnt)) begin
                n_fail++;
                $display("FAIL count_%s got %0d exp %0d t=%0t",
                         nm[k], gc[k], ms[k].cnt, $time);
            end
            n_chk++;
            if (gw[k] !== 1'(ms[k].wrap)) begin
                n_fail++;
                $display("FAIL wrap_%s got %b exp %0d t=%0t",
                         nm[k], gw[k], ms[k].wrap, $time);
            end
        end
    endtask

    task automatic test_reset();
        logic [3:0] gc[5];
        logic       gw[5];
        clr = 1'b1; clrc = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0; clrc = 1'b0;
        gc = '{ifa.count, ifb.count, ifd.count, ifu.count, ift.count};
        gw = '{ifa.wrap, ifb.wrap, ifd.wrap, ifu.wrap, ift.wrap};
        for (int k = 0; k < 5; k++) begin
            n_chk++;
            if (gc[k] !== 4'd0 || gw[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_%0d count %0d wrap %b exp 0/0",
                         k, gc[k], gw[k]);
            end
        end
        for (int k = 0; k < 3; k++) ms[k] = '{0, 0, 0};
    endtask

    task automatic test_count_up();
        cyc(1, 1, 1, 0, 0);
        for (int i = 0; i < 11; i++) begin
            cyc(0, 1, 1, 0, 0);
            n_chk++;
            if (ifa.count !== 4'((i + 1) % 10) ||
                ifa.wrap !== (i == 9) ||
                ifa.tc !== ((i + 1) % 10 == 9)) begin
                n_fail++;
                $display("FAIL up_%0d count %0d wrap %b tc %b exp %0d",
                         i, ifa.count, ifa.wrap, ifa.tc, (i + 1) % 10);
            end
        end
    endtask

    task automatic test_count_down();
        cyc(1, 1, 0, 0, 0);
        n_chk++;
        if (ifa.tc !== 1'b1) begin
            n_fail++;
            $display("FAIL down_first_tc got %b exp 1", ifa.tc);
        end
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, 0, 0, 0);
            n_chk++;
            if (ifa.count !== 4'(9 - i) || ifa.wrap !== (i == 0) ||
                ifa.tc !== (i == 9)) begin
                n_fail++;
                $display("FAIL down_%0d count %0d wrap %b tc %b exp %0d",
                         i, ifa.count, ifa.wrap, ifa.tc, 9 - i);
            end
        end
    endtask

    task automatic test_prescale();
        cyc(1, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 0);
        n_chk++;
        if (ifb.count !== 4'd1) begin
            n_fail++;
            $display("FAIL pre_hold got %0d exp 1", ifb.count);
        end
        cyc(0, 1, 1, 0, 0);
        n_chk++;
        if (ifb.count !== 4'd1) begin
            n_fail++;
            $display("FAIL pre_resume1 got %0d exp 1", ifb.count);
        end
        cyc(0, 1, 1, 0, 0);
        n_chk++;
        if (ifb.count !== 4'd2) begin
            n_fail++;
            $display("FAIL pre_resume2 got %0d exp 2", ifb.count);
        end
    endtask

    task automatic test_clear();
        int n;
        cyc(1, 1, 1, 0, 0);
        n = 0;
        while (ms[1].cnt != 7 && n < 100) begin
            cyc(0, 1, 1, 0, 0);
            n++;
        end
        n_chk++;
        if (n >= 100) begin
            n_fail++;
            $display("FAIL clr7_timeout got %0d exp <100", n);
        end
        cyc(1, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);
        n_chk++;
        if (ifb.count !== 4'd0) begin
            n_fail++;
            $display("FAIL clr7_pre got %0d exp 0", ifb.count);
        end
        cyc(0, 1, 1, 0, 0);
        n_chk++;
        if (ifb.count !== 4'd1) begin
            n_fail++;
            $display("FAIL clr7_step got %0d exp 1", ifb.count);
        end
        n = 0;
        while (!(ms[1].cnt == 9 && ms[1].pre == 2) && n < 100) begin
            cyc(0, 1, 1, 0, 0);
            n++;
        end
        n_chk++;
        if (ifb.tc !== 1'b1 || n >= 100) begin
            n_fail++;
            $display("FAIL clr9_tc got %b exp 1 (n=%0d)", ifb.tc, n);
        end
        cyc(1, 1, 1, 0, 0);
        n_chk++;
        if (ifb.count !== 4'd0 || ifb.wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL clr9 count %0d wrap %b exp 0/0",
                     ifb.count, ifb.wrap);
        end
    endtask

    task automatic test_cascade();
        clrc = 1'b1;
        ifu.en = 1'b1; ifu.up = 1'b1; ift.up = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clrc = 1'b0;
        for (int i = 0; i <= 100; i++) begin
            n_chk++;
            if ({ift.count, ifu.count} !==
                {4'((i / 10) % 10), 4'(i % 10)}) begin
                n_fail++;
                $display("FAIL casc_count_%0d got %0d%0d exp %0d",
                         i, ift.count, ifu.count, i % 100);
            end
            n_chk++;
            if (ift.tc !== (i == 99)) begin
                n_fail++;
                $display("FAIL casc_tc_%0d got %b exp %b",
                         i, ift.tc, i == 99);
            end
            n_chk++;
            if ({ift.wrap, ifu.wrap} !==
                {i == 100, i > 0 && i % 10 == 0}) begin
                n_fail++;
                $display("FAIL casc_wrap_%0d got %b%b", i,
                         ift.wrap, ifu.wrap);
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

`ifdef MOD_LOAD_EN
    task automatic test_load();
        cyc(0, 0, 1, 1, 12);
        n_chk++;
        if (ifa.count !== 4'd9) begin
            n_fail++;
            $display("FAIL load_sat got %0d exp 9", ifa.count);
        end
        cyc(0, 1, 1, 1, 4);
        n_chk++;
        if (ifa.count !== 4'd4 || ifa.wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL load_win count %0d wrap %b exp 4/0",
                     ifa.count, ifa.wrap);
        end
    endtask
`endif

    task automatic test_random();
        bit c, e, u, l;
        int d;
        cyc(1, 1, 1, 0, 0);
        for (int i = 0; i < 600; i++) begin
            c = ($urandom % 24) == 0;
            e = ($urandom % 4) != 0;
            u = ($urandom % 8) != 0 ? ms[0].cnt[0] : 1'($urandom);
            u = 1'($urandom % 2);
`ifdef MOD_LOAD_EN
            l = ($urandom % 10) == 0;
`else
            l = 1'b0;
`endif
            d = int'($urandom % 16);
            cyc(c, e, u, l, d);
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        clr = 1'b0;
        clrc = 1'b0;
        ifa.en = 1'b0; ifb.en = 1'b0; ifd.en = 1'b0; ifu.en = 1'b0;
        ifa.up = 1'b1; ifb.up = 1'b1; ifd.up = 1'b1;
        ifu.up = 1'b1; ift.up = 1'b1;
`ifdef MOD_LOAD_EN
        ifa.load = 1'b0; ifb.load = 1'b0; ifd.load = 1'b0;
        ifu.load = 1'b0; ift.load = 1'b0;
        ifa.din = '0; ifb.din = '0; ifd.din = '0;
        ifu.din = '0; ift.din = '0;
`endif
        @(negedge clk);
        test_reset();
        test_count_up();
        test_count_down();
        test_prescale();
        test_clear();
        test_cascade();
`ifdef MOD_LOAD_EN
        test_load();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mod_n_counter.md
Name: mod_n_counter

Overview:
Parametrised modulo-N counter for the lab display and timing chain. It counts up or down modulo MODULUS with a built-in clock prescaler. It produces a combinational terminal-count output so that instances can be cascaded, for example seconds units to tens to minutes. It also produces a registered wrap pulse for downstream event logic.

Parameters:
WIDTH, 4, count register width in bits; must satisfy 2**WIDTH >= MODULUS
MODULUS, 10, count sequence length; legal range 2..2**WIDTH
PRESCALE, 1, enabled clk cycles per count step; must be >= 1 (1 means step on every enabled cycle)

Ports:
clk  input  1  system clock; all state changes on rising edge
clr  input  1  reset, synchronous, active-high; highest priority
en  input  1  count enable; cascade input (tie to upstream tc)
up  input  1  direction: 1 = increment, 0 = decrement; sampled only on step cycles
count  output  WIDTH  current count value, 0..MODULUS-1
tc  output  1  terminal count, combinational; high on the step cycle that will wrap
wrap  output  1  registered one-cycle pulse, asserted the cycle after a wrap

Behaviour:
- Reset: clr=1 at a clk edge gives count=0, prescaler=0, wrap=0 on the next cycle. clr overrides en, up and load. Reset mid-prescale or mid-wrap discards all pending state.
- Prescaler: internal counter pre, range 0..PRESCALE-1.
  - When en=1, pre advances and wraps to 0 after PRESCALE-1.
  - When en=0, pre holds its value.
  - PRESCALE=1: pre is omitted and step = en.
- step (internal) = en & (pre == PRESCALE-1).
- Count update on step:
  - up=1: count==MODULUS-1 gives 0; otherwise count+1.
  - up=0: count==0 gives MODULUS-1; otherwise count-1.
  - No step: count holds.
- tc = step & ((up & count==MODULUS-1) | (~up & count==0)).
  - Purely combinational, no added latency, so a downstream en=tc steps in the same edge.
- wrap <= tc each cycle, giving exactly one cycle of pulse per wrap. wrap is 0 whenever the previous cycle had no wrap.
- Direction change between steps has no effect until the next step. No glitch or extra step occurs.
- count never leaves 0..MODULUS-1 under any input sequence.
- MODULUS == 2**WIDTH: wrap occurs via the explicit compare, not via overflow. Behaviour is identical.

Optional Feature:
MOD_LOAD_EN
- Defined: adds ports load (input, 1) and din (input, WIDTH).
  - Priority: clr > load > step.
  - load=1 gives count = din, or MODULUS-1 if din >= MODULUS.
  - Loading also clears pre to 0.
  - tc and wrap are forced to 0 on the load cycle (tc gated by ~load); wrap is 0 on the next cycle.
- Undefined: load and din ports do not exist and the count is changed only by clr and step.

Test Plan:
1. WIDTH=4, MODULUS=10, PRESCALE=1, en=1, up=1, from clr: count 0,1,…,9,0 on consecutive cycles. tc=1 only in the count=9 cycle; wrap=1 in the following cycle only.
2. Same config, up=0 after clr: count 0,9,8,…,0. tc=1 in each count=0 cycle, including the first cycle after clr. wrap follows one cycle later.
3. PRESCALE=3, en=1: count steps every 3rd cycle. Drop en for 5 cycles mid-prescale: count and pre freeze, and stepping resumes with the remaining cycles of the interrupted period.
4. Cascade two MODULUS=10 instances, units.tc to tens.en. Run 100 steps from 00: sequence 00..99 then 00 on the same edge. tens.tc is high only at 99; both wrap outputs pulse together.
5. clr asserted at count=7, and separately at count=9 with tc high: next cycle count=0, wrap=0, and pre=0 (verify with PRESCALE=3 that the next step takes 3 full cycles).
6. With MOD_LOAD_EN, MODULUS=10:
   - load=1, din=12 gives count=9 and tc=0 that cycle.
   - load=1 with din=4 while step is active: load wins, count=4, wrap=0.
